// File: rtl/mips_io_port_if.sv
// IN/OUT port bundle between the MIPS control unit, the I/O port block,
// and the external output sink / input source.
interface mips_io_port_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4
);
    // Control-unit side
    logic                         OutputWrite;
    logic                         InputRead;
    logic [WIDTH-1:0]             WriteData;
    logic [WIDTH-1:0]             ReadData;
    logic                         IOStall;
    // External output sink
    logic [WIDTH-1:0]             out_data;
    logic                         out_valid;
    logic                         out_ready;
    // External input source
    logic [WIDTH-1:0]             in_data;
    logic                         in_valid;
    logic                         in_ready;
    // Status
    logic [$clog2(OUT_DEPTH):0]   out_count;

    // The I/O port block is the responder.
    modport slave (
        input  OutputWrite, InputRead, WriteData, out_ready, in_data, in_valid,
        output ReadData, IOStall, out_data, out_valid, in_ready, out_count
    );

    // Control unit plus external devices, seen as one requester.
    modport master (
        output OutputWrite, InputRead, WriteData, out_ready, in_data, in_valid,
        input  ReadData, IOStall, out_data, out_valid, in_ready, out_count
    );
endinterface

// File: rtl/mips_io_port.sv
// Responder for MIPS IN/OUT instructions: OUT words queue in a small FIFO
// that drains over valid/ready; one input word is held for IN to consume.
// IOStall tells the control unit to hold state when a transfer cannot finish.
module mips_io_port #(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    mips_io_port_if.slave  io
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} in_state_t;

    // ---------------- Output FIFO ----------------
    logic [WIDTH-1:0] r_mem [OUT_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    // A full FIFO rejects the write even if a pop frees a slot this cycle;
    // the control unit retries next cycle.
    assign w_push  = io.OutputWrite && !w_full;
    assign w_pop   = !w_empty && io.out_ready;

    // Storage write; contents are meaningless until the pointers say otherwise.
    // NOTE: the data array has no reset -- pointers/count define validity,
    // and leaving it unreset lets it map onto plain RAM/flops without reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_tail] <= io.WriteData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign io.out_data  = r_mem[r_head];
    assign io.out_valid = !w_empty;
    assign io.out_count = r_count;

    // ---------------- Input holding register ----------------
    in_state_t        r_state;
    in_state_t        w_next_state;
    logic             w_in_held;
    logic             w_in_ready;
    logic [WIDTH-1:0] r_in_buf;

    // Input channel state register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and in_ready; in_ready is held low while reset is asserted.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_in_ready = Reset;
                if (io.in_valid && Reset) w_next_state = S_HELD;
            end
            S_HELD: begin
                if (io.InputRead) w_next_state = S_EMPTY;
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    // Capture the arriving word; it stays visible on ReadData after consumption.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_in_buf <= '0;
        end else if (io.in_valid && w_in_ready) begin
            r_in_buf <= io.in_data;
        end
    end

    assign w_in_held   = (r_state == S_HELD);
    assign io.in_ready = w_in_ready;
    assign io.ReadData = r_in_buf;

    // OUT and IN stall conditions are independent; either one holds the core.
    assign io.IOStall = (io.OutputWrite && w_full) || (io.InputRead && !w_in_held);

endmodule
